// File: rtl/write_buffer.sv
// write_buffer: 512-bit in-order write-data FIFO with FWFT read port and almost-empty flag (optional cnt_o via WBUFFER_CNT_EN).
// Latency: a line written at edge N is visible on rdata_o right after edge N; a pop advances the head at the edge.
// Backpressure: ready_o drops when DEPTH lines are held; writes while full and pops while empty are ignored.
module write_buffer #(
    parameter int DEPTH     = 4,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_i,
    input  logic [511:0]               wdata_i,
    output logic                       ready_o,
    output logic                       Aempty_o,
    input  logic                       rden_i,
    output logic [511:0]               rdata_o
`ifdef WBUFFER_CNT_EN
    ,
    output logic [$clog2(DEPTH):0]     cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          head_vld;
    logic [511:0]  head_dat;
    logic [CW-1:0] cnt;

    wb_fifo #(
        .WIDTH (512),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_vld  (valid_i),
        .wr_dat  (wdata_i),
        .wr_rdy  (ready_o),
        .rd_rdy  (rden_i),
        .rd_vld  (head_vld),
        .rd_dat  (head_dat),
        .cnt     (cnt)
    );

    // Stale array contents must never leak out, so the head is masked when empty.
    assign rdata_o  = head_vld ? head_dat : '0;
    assign Aempty_o = (cnt <= CW'(AEMPTY_TH));

`ifdef WBUFFER_CNT_EN
    assign cnt_o = cnt;
`endif

endmodule

// wb_fifo: generic single-clock FIFO, FWFT head, registered occupancy count.
// Latency: write visible at head one edge after acceptance; no same-cycle write-to-read bypass.
// Backpressure: wr_rdy low when full; rd_vld low when empty.
module wb_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   wr_rdy,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_fire;
    logic             rd_fire;

    // Both handshakes look only at the registered count, so a pop never frees a slot for a same-cycle write.
    assign wr_rdy  = (cnt < CW'(DEPTH));
    assign rd_vld  = (cnt != '0);
    assign wr_fire = wr_vld & wr_rdy;
    assign rd_fire = rd_rdy & rd_vld;
    assign rd_dat  = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_fire) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_fire) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (DEPTH=4, AEMPTY_TH=1).
module tb_write_buffer;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [511:0] wdata_i;
    logic         ready_o;
    logic         Aempty_o;
    logic         rden_i;
    logic [511:0] rdata_o;
`ifdef WBUFFER_CNT_EN
    logic [2:0]   cnt_o;
`endif

    int checks;
    int failures;

    write_buffer #(
        .DEPTH     (4),
        .AEMPTY_TH (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .Aempty_o (Aempty_o),
        .rden_i   (rden_i),
        .rdata_o  (rdata_o)
`ifdef WBUFFER_CNT_EN
        ,
        .cnt_o    (cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks head data plus both flags in one go.
    task automatic chk3(input string tag, input logic [511:0] d, input logic rdy, input logic ae);
        chk({tag, ".rdata"}, rdata_o, d);
        chk({tag, ".ready"}, {511'd0, ready_o}, {511'd0, rdy});
        chk({tag, ".aempty"}, {511'd0, Aempty_o}, {511'd0, ae});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        wdata_i  = '0;
        rden_i   = 1'b0;

        // Reset
        tick();
        chk3("reset_held", 512'h0, 1'b1, 1'b1);
        rst_n = 1'b1;
        tick();
        chk3("reset_rel", 512'h0, 1'b1, 1'b1);
`ifdef WBUFFER_CNT_EN
        chk("reset_cnt", {509'd0, cnt_o}, 512'd0);
`endif

        // Basic order: 0xaa, idle, 0xbb, then rden held high
        valid_i = 1'b1; wdata_i = 512'haa;
        tick();
        chk3("basic_w1", 512'haa, 1'b1, 1'b1);
        valid_i = 1'b0;
        tick();
        chk3("basic_idle", 512'haa, 1'b1, 1'b1);
        valid_i = 1'b1; wdata_i = 512'hbb;
        tick();
        chk3("basic_w2", 512'haa, 1'b1, 1'b0);
        valid_i = 1'b0; rden_i = 1'b1;
        tick();
        chk3("basic_pop1", 512'hbb, 1'b1, 1'b1);
        tick();
        chk3("basic_pop2", 512'h0, 1'b1, 1'b1);
        tick();
        chk3("basic_pop_empty", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        // Full: 1..4 back-to-back, 5th dropped, drain 1,2,3,4
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1; wdata_i = 512'(i);
            tick();
            chk3($sformatf("full_w%0d", i), 512'h1, (i < 4), (i <= 1));
        end
        wdata_i = 512'h5;
        tick();
        chk3("full_drop", 512'h1, 1'b0, 1'b0);
`ifdef WBUFFER_CNT_EN
        chk("full_cnt", {509'd0, cnt_o}, 512'd4);
`endif
        valid_i = 1'b0; rden_i = 1'b1;
        tick();
        chk3("full_d1", 512'h2, 1'b1, 1'b0);
        tick();
        chk3("full_d2", 512'h3, 1'b1, 1'b0);
        tick();
        chk3("full_d3", 512'h4, 1'b1, 1'b1);
        tick();
        chk3("full_d4", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        // Simultaneous read+write with cnt=2
        valid_i = 1'b1; wdata_i = 512'h10;
        tick();
        wdata_i = 512'h11;
        tick();
        chk3("sim_pre", 512'h10, 1'b1, 1'b0);
        wdata_i = 512'hcc; rden_i = 1'b1;
        tick();
        chk3("sim_both", 512'h11, 1'b1, 1'b0);
`ifdef WBUFFER_CNT_EN
        chk("sim_cnt", {509'd0, cnt_o}, 512'd2);
`endif
        valid_i = 1'b0;
        tick();
        chk3("sim_d1", 512'hcc, 1'b1, 1'b1);
        tick();
        chk3("sim_d2", 512'h0, 1'b1, 1'b1);

        // Simultaneous read+write when empty: write wins, read ignored
        valid_i = 1'b1; wdata_i = 512'hee;
        tick();
        chk3("empty_both", 512'hee, 1'b1, 1'b1);
        valid_i = 1'b0;
        tick();
        chk3("empty_both_pop", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        // Simultaneous read+write when full: read wins, write rejected
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; wdata_i = 512'h21 + 512'(i);
            tick();
        end
        chk3("fullboth_pre", 512'h21, 1'b0, 1'b0);
        wdata_i = 512'h25; rden_i = 1'b1;
        tick();
        chk3("fullboth", 512'h22, 1'b1, 1'b0);
        valid_i = 1'b0;
        tick();
        chk3("fullboth_d1", 512'h23, 1'b1, 1'b0);
        tick();
        chk3("fullboth_d2", 512'h24, 1'b1, 1'b1);
        tick();
        chk3("fullboth_d3", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        // Wrap-around: 6 writes interleaved with reads
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; wdata_i = 512'h30 + 512'(i);
            rden_i  = (i > 0);
            tick();
            chk3($sformatf("wrap_%0d", i), 512'h30 + 512'(i), 1'b1, 1'b1);
        end
        valid_i = 1'b0; rden_i = 1'b1;
        tick();
        chk3("wrap_end", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        // Mid-operation reset with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; wdata_i = 512'h41 + 512'(i);
            tick();
        end
        valid_i = 1'b0;
        chk3("mid_pre", 512'h41, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk3("mid_async", 512'h0, 1'b1, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk3("mid_after", 512'h0, 1'b1, 1'b1);
        valid_i = 1'b1; wdata_i = 512'hdd;
        tick();
        chk3("mid_wdd", 512'hdd, 1'b1, 1'b1);
        valid_i = 1'b0; rden_i = 1'b1;
        tick();
        chk3("mid_pop", 512'h0, 1'b1, 1'b1);
        rden_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
